// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch sequencer
package fetch_ctrl_pkg;
   localparam int INST_BYTES = 4;
   localparam int PC_BITS = 64;
   typedef logic [PC_BITS-1:0] pc_t;
   typedef logic [31:0] inst_t;
   typedef enum logic [1:0] {FETCH, WAIT, DRAIN, STALL} fetch_state_e;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: single-outstanding I-cache request/response channel
interface fetch_ctrl_if import fetch_ctrl_pkg::*; #(parameter int PC_W = 64);
   logic ic_req_valid;
   logic [PC_W-1:0] ic_req_PC;
   logic ic_resp_valid;
   inst_t [1:0] ic_resp_inst;
   modport master (output ic_req_valid, ic_req_PC, input ic_resp_valid, ic_resp_inst);
   modport slave (input ic_req_valid, ic_req_PC, output ic_resp_valid, ic_resp_inst);
endinterface

// File: rtl/fetch_npc_sel.sv
// fetch_npc_sel: lane count and next fetch PC for the current request
module fetch_npc_sel import fetch_ctrl_pkg::*; #(parameter int PC_W = 64) (
   input  logic [PC_W-1:0] fetch_PC,
   input  logic [1:0] ib_nAvai,
   input  logic [1:0] bp_pred_taken,
   input  logic [1:0][PC_W-1:0] bp_pred_NPC,
   output logic [1:0] n_lanes,
   output logic [PC_W-1:0] next_PC
);
   // a taken lane0 drops lane1 regardless of free slots
   assign n_lanes = bp_pred_taken[0] ? 2'd1 : ib_nAvai[1] ? 2'd2 : ib_nAvai;
   assign next_PC = bp_pred_taken[0] ? bp_pred_NPC[0] :
                    (n_lanes == 2'd2 && bp_pred_taken[1]) ? bp_pred_NPC[1] :
                    fetch_PC + PC_W'(n_lanes) * PC_W'(INST_BYTES);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer issuing one I-cache request at a time into the InstrBuffer
module fetch_ctrl import fetch_ctrl_pkg::*; #(
   parameter int PC_W = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic br_fub_pred_wrong,
   input  logic [PC_W-1:0] br_recover_PC,
   input  logic [1:0] ib_nAvai,
   input  logic [1:0] bp_pred_taken,
   input  logic [1:0][PC_W-1:0] bp_pred_NPC,
   fetch_ctrl_if.master ic,
   output logic [1:0] if_valid_out,
   output inst_t [1:0] if_inst_out,
   output logic [1:0][PC_W-1:0] if_not_taken_NPC,
   output logic [PC_W-1:0] fetch_PC,
   output logic [CNT_W-1:0] stall_cycles
);
   fetch_state_e state;
   logic [1:0] n_lanes, lat_n;
   logic [PC_W-1:0] next_PC, lat_pc, lat_npc;
   logic issue, resp_ok;
   fetch_npc_sel #(.PC_W(PC_W)) u_sel (
      .fetch_PC(fetch_PC), .ib_nAvai(ib_nAvai), .bp_pred_taken(bp_pred_taken),
      .bp_pred_NPC(bp_pred_NPC), .n_lanes(n_lanes), .next_PC(next_PC)
   );
   assign issue = state == FETCH && ib_nAvai != 2'd0 && !br_fub_pred_wrong && !reset;
   assign resp_ok = state == WAIT && ic.ic_resp_valid && !br_fub_pred_wrong && !reset;
   assign ic.ic_req_valid = issue;
   assign ic.ic_req_PC = fetch_PC;
   assign if_valid_out = resp_ok ? (lat_n == 2'd2 ? 2'b11 : 2'b01) : 2'b00;
   assign if_inst_out = ic.ic_resp_inst;
   assign if_not_taken_NPC[0] = lat_pc + PC_W'(INST_BYTES);
   assign if_not_taken_NPC[1] = lat_pc + PC_W'(2 * INST_BYTES);
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         fetch_PC <= RESET_PC;
         stall_cycles <= '0;
         lat_n <= '0;
         lat_pc <= '0;
         lat_npc <= '0;
      end else begin
         if (state == STALL && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
         if (br_fub_pred_wrong) begin
            fetch_PC <= br_recover_PC;
            // an in-flight request must still be drained before refetching
            if (state == WAIT || state == DRAIN) state <= ic.ic_resp_valid ? FETCH : DRAIN;
         end else begin
            case (state)
               FETCH: begin
                  state <= issue ? WAIT : STALL;
                  if (issue) begin
                     lat_n <= n_lanes;
                     lat_pc <= fetch_PC;
                     lat_npc <= next_PC;
                  end
               end
               WAIT: if (ic.ic_resp_valid) begin
                  fetch_PC <= lat_npc;
                  state <= FETCH;
               end
               DRAIN: if (ic.ic_resp_valid) state <= FETCH;
               default: if (ib_nAvai != 2'd0) state <= FETCH;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven directed checks of the fetch sequencer
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;
   typedef struct {
      logic rst, br;
      pc_t rpc;
      logic [1:0] nav, tk;
      pc_t n0, n1;
      logic rv;
      logic req;
      pc_t rq_pc;
      logic [1:0] vo;
      pc_t nt0, nt1, fpc;
      logic [15:0] stl;
   } vec_t;
   logic clk = 0, reset = 1, br_fub_pred_wrong = 0;
   pc_t br_recover_PC = '0;
   logic [1:0] ib_nAvai = 2'd3, bp_pred_taken = '0;
   logic [1:0][63:0] bp_pred_NPC = '0;
   logic [1:0] if_valid_out;
   inst_t [1:0] if_inst_out;
   logic [1:0][63:0] if_not_taken_NPC;
   pc_t fetch_PC;
   logic [15:0] stall_cycles;
   int checks = 0, errors = 0, cnum = 0;
   vec_t tbl[$];
   fetch_ctrl_if #(.PC_W(64)) ic ();
   fetch_ctrl dut (
      .clk(clk), .reset(reset), .br_fub_pred_wrong(br_fub_pred_wrong), .br_recover_PC(br_recover_PC),
      .ib_nAvai(ib_nAvai), .bp_pred_taken(bp_pred_taken), .bp_pred_NPC(bp_pred_NPC), .ic(ic.master),
      .if_valid_out(if_valid_out), .if_inst_out(if_inst_out), .if_not_taken_NPC(if_not_taken_NPC),
      .fetch_PC(fetch_PC), .stall_cycles(stall_cycles)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(logic rst, logic br, pc_t rpc, logic [1:0] nav, logic [1:0] tk, pc_t n0, pc_t n1,
                               logic rv, logic req, pc_t rq_pc, logic [1:0] vo, pc_t nt0, pc_t nt1, pc_t fpc,
                               logic [15:0] stl);
      return '{rst, br, rpc, nav, tk, n0, n1, rv, req, rq_pc, vo, nt0, nt1, fpc, stl};
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cnum, act, exp);
      end
   endtask
   task automatic cyc(vec_t v);
      @(posedge clk);
      #1;
      cnum++;
      reset = v.rst;
      br_fub_pred_wrong = v.br;
      br_recover_PC = v.rpc;
      ib_nAvai = v.nav;
      bp_pred_taken = v.tk;
      bp_pred_NPC[0] = v.n0;
      bp_pred_NPC[1] = v.n1;
      ic.ic_resp_valid = v.rv;
      ic.ic_resp_inst[0] = 32'hC0DE_0000 + 32'(cnum);
      ic.ic_resp_inst[1] = 32'hBEEF_0000 + 32'(cnum);
      #1;
      chk("req_valid", 64'(ic.ic_req_valid), 64'(v.req));
      if (v.req) chk("req_PC", ic.ic_req_PC, v.rq_pc);
      chk("valid_out", 64'(if_valid_out), 64'(v.vo));
      chk("fetch_PC", fetch_PC, v.fpc);
      chk("stall_cycles", 64'(stall_cycles), 64'(v.stl));
      if (v.vo != 2'b00) begin
         chk("npc0", if_not_taken_NPC[0], v.nt0);
         chk("npc1", if_not_taken_NPC[1], v.nt1);
         chk("inst0", 64'(if_inst_out[0]), 64'(32'hC0DE_0000 + 32'(cnum)));
         chk("inst1", 64'(if_inst_out[1]), 64'(32'hBEEF_0000 + 32'(cnum)));
      end
   endtask
   initial begin
      ic.ic_resp_valid = 0;
      ic.ic_resp_inst = '0;
      //         rst br rpc    nav tk n0     n1     rv req rq_pc  vo     nt0    nt1    fpc    stl
      tbl.push_back(mk(1, 0, 0,     3, 0, 0,     0,     0, 0, 0,     2'b00, 0,     0,     0,     0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 1, 0,     2'b00, 0,     0,     0,     0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b11, 4,     8,     0,     0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 1, 8,     2'b00, 0,     0,     8,     0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b11, 12,    16,    8,     0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 1, 16,    2'b00, 0,     0,     16,    0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b11, 20,    24,    16,    0));
      tbl.push_back(mk(0, 1, 'h40,  3, 0, 0,     0,     0, 0, 0,     2'b00, 0,     0,     24,    0));
      tbl.push_back(mk(0, 0, 0,     1, 0, 0,     0,     0, 1, 'h40,  2'b00, 0,     0,     'h40,  0));
      tbl.push_back(mk(0, 0, 0,     1, 0, 0,     0,     1, 0, 0,     2'b01, 'h44,  'h48,  'h40,  0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 1, 'h44,  2'b00, 0,     0,     'h44,  0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b11, 'h48,  'h4c,  'h44,  0));
      tbl.push_back(mk(0, 1, 'h20,  3, 0, 0,     0,     0, 0, 0,     2'b00, 0,     0,     'h4c,  0));
      tbl.push_back(mk(0, 0, 0,     3, 1, 'h100, 'h300, 0, 1, 'h20,  2'b00, 0,     0,     'h20,  0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b01, 'h24,  'h28,  'h20,  0));
      tbl.push_back(mk(0, 0, 0,     3, 2, 0,     'h180, 0, 1, 'h100, 2'b00, 0,     0,     'h100, 0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b11, 'h104, 'h108, 'h100, 0));
      tbl.push_back(mk(0, 0, 0,     1, 2, 0,     'h900, 0, 1, 'h180, 2'b00, 0,     0,     'h180, 0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b01, 'h184, 'h188, 'h180, 0));
      tbl.push_back(mk(0, 1, 'h80,  3, 0, 0,     0,     0, 0, 0,     2'b00, 0,     0,     'h184, 0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 1, 'h80,  2'b00, 0,     0,     'h80,  0));
      tbl.push_back(mk(0, 1, 'h200, 3, 0, 0,     0,     0, 0, 0,     2'b00, 0,     0,     'h80,  0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 0, 0,     2'b00, 0,     0,     'h200, 0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b00, 0,     0,     'h200, 0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 1, 'h200, 2'b00, 0,     0,     'h200, 0));
      tbl.push_back(mk(0, 1, 'h300, 3, 0, 0,     0,     1, 0, 0,     2'b00, 0,     0,     'h200, 0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 1, 'h300, 2'b00, 0,     0,     'h300, 0));
      tbl.push_back(mk(1, 0, 0,     3, 0, 0,     0,     0, 0, 0,     2'b00, 0,     0,     'h300, 0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     0, 1, 0,     2'b00, 0,     0,     0,     0));
      tbl.push_back(mk(0, 0, 0,     3, 0, 0,     0,     1, 0, 0,     2'b11, 4,     8,     0,     0));
      repeat (2) @(posedge clk);
      foreach (tbl[i]) cyc(tbl[i]);
      // stall: ib_nAvai=0 for five cycles starting in FETCH at PC 8, then 2
      for (int i = 0; i < 5; i++)
         cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 8, (i == 0) ? 16'd0 : 16'(i - 1)));
      cyc(mk(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 8, 4));
      cyc(mk(0, 0, 0, 2, 0, 0, 0, 0, 1, 8, 2'b00, 0, 0, 8, 5));
      cyc(mk(0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 2'b11, 12, 16, 8, 5));
      cyc(mk(0, 0, 0, 3, 0, 0, 0, 0, 1, 16, 2'b00, 0, 0, 16, 5));
      // reset mid-WAIT clears the counter and restarts from RESET_PC
      cyc(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 16, 5));
      cyc(mk(0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
      cyc(mk(0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 2'b11, 4, 8, 0, 0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
